// File: rtl/hit_detector.sv
// rtl/hit_detector.sv - per-frame bullet/player collision scanner
//
// On an accepted frame_start the block latches the player position and reads
// every entry of the bullet table (synchronous RAM, one cycle read latency),
// testing each valid bullet against a square hitbox around the player. The
// scan stops at the first hit and raises collision for one cycle.
//
// Ports:
//   clk, hard_reset    clock and synchronous active-high reset
//   game_en            scanning allowed only while high; falling aborts a scan
//   frame_start        one-cycle pulse that requests a scan
//   player_x/player_y  player centre, latched when a scan is accepted
//   bullet_rd_en       bullet RAM read enable (registered)
//   bullet_addr        bullet RAM read address (registered, holds when idle)
//   bullet_data        {valid, x, y} for the address issued one cycle earlier
//   collision          one-cycle pulse on the first hit of a scan
//   hit_index          index of the last bullet that hit, held until next hit
//   scan_busy          high while a scan is in progress
//   frame_overrun      sticky: frame_start arrived while a scan was running
module hit_detector #(
    parameter int NUM_BULLETS = 64,
    parameter int ADDR_W      = 6,
    parameter int COORD_W     = 10,
    parameter int HIT_RADIUS  = 3
) (
    input  logic                 clk,
    input  logic                 hard_reset,
    input  logic                 game_en,
    input  logic                 frame_start,
    input  logic [COORD_W-1:0]   player_x,
    input  logic [COORD_W-1:0]   player_y,
    output logic                 bullet_rd_en,
    output logic [ADDR_W-1:0]    bullet_addr,
    input  logic [2*COORD_W:0]   bullet_data,
    output logic                 collision,
    output logic [ADDR_W-1:0]    hit_index,
    output logic                 scan_busy,
    output logic                 frame_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_BULLETS - 1);
    localparam logic [COORD_W:0]   RADIUS    = (COORD_W + 1)'(HIT_RADIUS);

    state_t              state, state_nxt;
    logic [COORD_W-1:0]  px_q, py_q, px_nxt, py_nxt;
    logic                rd_en_nxt, busy_nxt, coll_nxt, ovr_nxt;
    logic [ADDR_W-1:0]   addr_nxt, hit_idx_nxt;

    // Tracks which address the current bullet_data belongs to.
    logic                cmp_pending;
    logic [ADDR_W-1:0]   cmp_idx;

    // Absolute differences are taken one bit wider so that positions at
    // opposite ends of the coordinate range never alias to a near miss.
    logic [COORD_W:0]    bx_w, by_w, px_w, py_w, dx, dy;
    logic                hit;

    assign bx_w = {1'b0, bullet_data[2*COORD_W-1:COORD_W]};
    assign by_w = {1'b0, bullet_data[COORD_W-1:0]};
    assign px_w = {1'b0, px_q};
    assign py_w = {1'b0, py_q};
    assign dx   = (bx_w >= px_w) ? (bx_w - px_w) : (px_w - bx_w);
    assign dy   = (by_w >= py_w) ? (by_w - py_w) : (py_w - by_w);
    assign hit  = cmp_pending && bullet_data[2*COORD_W] &&
                  (dx <= RADIUS) && (dy <= RADIUS);

    always_comb begin
        state_nxt   = state;
        rd_en_nxt   = bullet_rd_en;
        addr_nxt    = bullet_addr;
        busy_nxt    = scan_busy;
        coll_nxt    = 1'b0;
        hit_idx_nxt = hit_index;
        px_nxt      = px_q;
        py_nxt      = py_q;
        ovr_nxt     = frame_overrun | (frame_start & scan_busy);

        case (state)
            IDLE: begin
                if (frame_start && game_en) begin
                    state_nxt = SCAN;
                    rd_en_nxt = 1'b1;
                    addr_nxt  = '0;
                    busy_nxt  = 1'b1;
                    px_nxt    = player_x;
                    py_nxt    = player_y;
                end
            end
            SCAN: begin
                if (!game_en) begin
                    // Abort wins over a hit compared in the same cycle.
                    state_nxt = IDLE;
                    rd_en_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (hit) begin
                    // The read issued this cycle is speculative and dropped.
                    state_nxt   = IDLE;
                    rd_en_nxt   = 1'b0;
                    busy_nxt    = 1'b0;
                    coll_nxt    = 1'b1;
                    hit_idx_nxt = cmp_idx;
                end else if (bullet_addr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                    rd_en_nxt = 1'b0;
                end else begin
                    addr_nxt = bullet_addr + 1'b1;
                end
            end
            DRAIN: begin
                // Final compare of the last entry; the scan ends either way.
                state_nxt = IDLE;
                rd_en_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (game_en && hit) begin
                    coll_nxt    = 1'b1;
                    hit_idx_nxt = cmp_idx;
                end
            end
            default: begin
                state_nxt = IDLE;
                rd_en_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (hard_reset) begin
            state         <= IDLE;
            bullet_rd_en  <= 1'b0;
            bullet_addr   <= '0;
            scan_busy     <= 1'b0;
            collision     <= 1'b0;
            hit_index     <= '0;
            frame_overrun <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            cmp_pending   <= 1'b0;
            cmp_idx       <= '0;
        end else begin
            state         <= state_nxt;
            bullet_rd_en  <= rd_en_nxt;
            bullet_addr   <= addr_nxt;
            scan_busy     <= busy_nxt;
            collision     <= coll_nxt;
            hit_index     <= hit_idx_nxt;
            frame_overrun <= ovr_nxt;
            px_q          <= px_nxt;
            py_q          <= py_nxt;
            cmp_pending   <= bullet_rd_en;
            cmp_idx       <= bullet_addr;
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
// tb/tb_hit_detector.sv - scoreboard bench for hit_detector
module tb_hit_detector;

    localparam int N  = 64;
    localparam int AW = 6;
    localparam int CW = 10;
    localparam int R  = 3;

    logic            clk = 1'b0;
    logic            hard_reset = 1'b1;
    logic            game_en = 1'b0;
    logic            frame_start = 1'b0;
    logic [CW-1:0]   player_x = '0;
    logic [CW-1:0]   player_y = '0;
    logic            bullet_rd_en;
    logic [AW-1:0]   bullet_addr;
    logic [2*CW:0]   bullet_data = '0;
    logic            collision;
    logic [AW-1:0]   hit_index;
    logic            scan_busy;
    logic            frame_overrun;

    always #5 clk = ~clk;

    hit_detector #(.NUM_BULLETS(N), .ADDR_W(AW), .COORD_W(CW), .HIT_RADIUS(R)) dut (
        .clk(clk), .hard_reset(hard_reset), .game_en(game_en),
        .frame_start(frame_start), .player_x(player_x), .player_y(player_y),
        .bullet_rd_en(bullet_rd_en), .bullet_addr(bullet_addr),
        .bullet_data(bullet_data), .collision(collision), .hit_index(hit_index),
        .scan_busy(scan_busy), .frame_overrun(frame_overrun)
    );

    // Bullet RAM model: one cycle read latency.
    logic [2*CW:0] mem [N];
    always @(posedge clk) if (bullet_rd_en) bullet_data <= mem[bullet_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int end_cyc;
        bit coll;
        int idx;
    } exp_t;
    exp_t expq[$];

    int rd_addr_log[$];
    int rd_cyc_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first valid bullet whose true axis distances are within R.
    function automatic int ref_first_hit(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            int bx, by, ax, ay;
            bx = int'(mem[i][2*CW-1:CW]);
            by = int'(mem[i][CW-1:0]);
            ax = (bx > px) ? bx - px : px - bx;
            ay = (by > py) ? by - py : py - by;
            if (mem[i][2*CW] && ax <= R && ay <= R) return i;
        end
        return -1;
    endfunction

    function automatic logic [2*CW:0] entry(input bit v, input int x, input int y);
        logic [CW-1:0] xs, ys;
        xs = CW'(x);
        ys = CW'(y);
        return {v, xs, ys};
    endfunction

    // Monitor: every end of scan (scan_busy falling) is matched to the oldest
    // expectation; a collision pulse anywhere else is an error.
    bit   prev_busy = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (bullet_rd_en === 1'b1) begin
            rd_addr_log.push_back(int'(bullet_addr));
            rd_cyc_log.push_back(cyc);
        end
        if (prev_busy && scan_busy === 1'b0) begin
            if (expq.size() == 0) begin
                check("unexpected_scan_end", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("scan_end_cycle", cyc, mon_e.end_cyc);
                check("collision", {31'd0, collision}, {31'd0, mon_e.coll});
                if (mon_e.coll) check("hit_index", {26'd0, hit_index}, mon_e.idx);
            end
        end else if (collision === 1'b1) begin
            check("stray_collision", 1, 0);
        end
        prev_busy = (scan_busy === 1'b1);
    end

    task automatic clear_mem();
        for (int i = 0; i < N; i++) mem[i] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_collision"}, {31'd0, collision}, 0);
        check({tag, "_scan_busy"}, {31'd0, scan_busy}, 0);
        check({tag, "_rd_en"}, {31'd0, bullet_rd_en}, 0);
        check({tag, "_addr"}, {26'd0, bullet_addr}, 0);
        check({tag, "_hit_index"}, {26'd0, hit_index}, 0);
        check({tag, "_overrun"}, {31'd0, frame_overrun}, 0);
    endtask

    // One scan started at the next negedge (cycle 0 = start).  The loop runs
    // until the cycle before the expected end, so a following scan is issued
    // in the very cycle the previous one ends.  linger adds that end cycle.
    task automatic run_scan(input int px, input int py, input int abort_k,
                            input int reset_k, input int ovr_k, input bit linger,
                            output int start);
        int   hi, rel_end, last_k;
        bit   coll;
        exp_t e;
        hi      = ref_first_hit(px, py);
        coll    = (hi >= 0);
        rel_end = coll ? 3 + hi : N + 2;
        if (abort_k >= 0 && abort_k < rel_end) begin rel_end = abort_k + 1; coll = 1'b0; end
        else abort_k = -1;
        if (reset_k >= 0 && reset_k < rel_end) begin rel_end = reset_k + 1; coll = 1'b0; end
        else reset_k = -1;
        @(negedge clk);
        start       = cyc;
        player_x    = CW'(px);
        player_y    = CW'(py);
        frame_start = 1'b1;
        game_en     = 1'b1;
        hard_reset  = 1'b0;
        e.end_cyc = start + rel_end;
        e.coll    = coll;
        e.idx     = hi;
        expq.push_back(e);
        last_k = linger ? rel_end : rel_end - 1;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            frame_start = (k == ovr_k);
            game_en     = (k != abort_k);
            hard_reset  = (k == reset_k);
            player_x    = CW'($urandom);
            player_y    = CW'($urandom);
            if (abort_k >= 0 && k == abort_k + 1) begin
                check("abort_busy", {31'd0, scan_busy}, 0);
                check("abort_rd_en", {31'd0, bullet_rd_en}, 0);
            end
            if (reset_k >= 0 && k == reset_k + 1) check_all_zero("midreset");
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int st, bad, px, py;
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st, bad, px, py, ab;
        clear_mem();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        hard_reset = 1'b0;
        game_en    = 1'b1;

        // frame_start with game_en low is ignored.
        @(negedge clk); frame_start = 1'b1; game_en = 1'b0;
        @(negedge clk); frame_start = 1'b0; game_en = 1'b1;
        @(negedge clk);
        check("ignored_start_busy", {31'd0, scan_busy}, 0);

        // Empty table: full address sweep, no collision.
        rd_addr_log.delete(); rd_cyc_log.delete();
        run_scan(100, 100, -1, -1, -1, 1'b0, st);
        settle(3);
        check("sweep_reads", rd_addr_log.size(), N);
        bad = 0;
        foreach (rd_addr_log[i])
            if (rd_addr_log[i] != i || rd_cyc_log[i] != st + 1 + i) bad++;
        check("sweep_sequence", bad, 0);

        // Single hit at entry 5: pulse in cycle 8, reads stop at address 6.
        mem[5] = entry(1, 102, 97);
        rd_addr_log.delete(); rd_cyc_log.delete();
        run_scan(100, 100, -1, -1, -1, 1'b0, st);
        settle(3);
        check("hit5_reads", rd_addr_log.size(), 7);
        check("hit5_last_addr", rd_addr_log[$], 6);
        check("hit5_last_rd_cycle", rd_cyc_log[$], st + 7);
        clear_mem();

        // Hitbox corner, one past, invalid entry, and no-wrap distance.
        mem[0] = entry(1, 103, 103);   run_scan(100, 100, -1, -1, -1, 1'b0, st);
        mem[0] = entry(1, 104, 100);   run_scan(100, 100, -1, -1, -1, 1'b0, st);
        mem[0] = entry(0, 100, 100);   run_scan(100, 100, -1, -1, -1, 1'b0, st);
        mem[0] = entry(1, 1023, 0);    run_scan(0, 0, -1, -1, -1, 1'b0, st);
        mem[0] = entry(1, 1021, 1020); run_scan(1023, 1023, -1, -1, -1, 1'b0, st);
        clear_mem();

        // Overrun: extra frame_start at cycle 20 is dropped and latched.
        run_scan(100, 100, -1, -1, 20, 1'b0, st);
        run_scan(100, 100, -1, -1, -1, 1'b0, st);
        settle(3);
        check("overrun_sticky", {31'd0, frame_overrun}, 1);
        @(negedge clk); hard_reset = 1'b1;
        @(negedge clk); hard_reset = 1'b0;
        check("overrun_cleared", {31'd0, frame_overrun}, 0);

        // Aborts with a hit planted at entry 40.
        mem[40] = entry(1, 500, 501);
        run_scan(500, 500, 10, -1, -1, 1'b1, st);
        run_scan(500, 500, -1, 30, -1, 1'b1, st);
        run_scan(500, 500, -1, -1, -1, 1'b0, st);
        clear_mem();

        // Randomized tables, player positions and occasional aborts.
        for (int t = 0; t < 30; t++) begin
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    mem[i] = entry($urandom_range(0, 1) == 1,
                                   (px + int'($urandom_range(0, 14)) - 7) & 1023,
                                   (py + int'($urandom_range(0, 14)) - 7) & 1023);
                else
                    mem[i] = entry($urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)),
                                   int'($urandom_range(0, 1023)));
            end
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 60)) : -1;
            run_scan(px, py, ab, -1, -1, ab >= 0, st);
        end

        settle(N + 8);
        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Per-frame collision scanner that sits directly upstream of the game-control FSM and produces its single-cycle `collision` input.
- On each `frame_start` it walks the bullet position table (synchronous RAM, 1-cycle read latency).
- Each valid bullet is compared against a square hitbox around the latched player position.
- The scan stops at the first hit and emits one `collision` pulse.

Parameters:
- NUM_BULLETS, 64: bullet table entries; must be a power of two.
- ADDR_W, 6: log2(NUM_BULLETS).
- COORD_W, 10: x/y coordinate width, unsigned.
- HIT_RADIUS, 3: hitbox half-width in pixels; a hit requires both axis distances <= HIT_RADIUS.

Ports:
- clk, input, 1: system clock.
- hard_reset, input, 1: reset.
- game_en, input, 1: from the game FSM; scanning is allowed only while high.
- frame_start, input, 1: one-cycle pulse at start of vertical blank.
- player_x, input, COORD_W: player centre x, sampled when a scan is accepted.
- player_y, input, COORD_W: player centre y, sampled when a scan is accepted.
- bullet_rd_en, output, 1: bullet RAM read enable (registered).
- bullet_addr, output, ADDR_W: bullet RAM read address (registered).
- bullet_data, input, 1+2*COORD_W: {valid, x, y}, valid for the address presented one cycle earlier.
- collision, output, 1: one-cycle hit pulse to the game FSM.
- hit_index, output, ADDR_W: index of the last bullet that hit; held until the next hit.
- scan_busy, output, 1: high while a scan is in progress.
- frame_overrun, output, 1: sticky flag; set when frame_start arrives during a scan.

Behaviour:
- Clocking and reset: single clock `clk`. Reset `hard_reset` is synchronous and active-high.
  - On reset: state IDLE.
  - All outputs 0: collision, scan_busy, bullet_rd_en, bullet_addr, hit_index, frame_overrun.
  - Latched player position cleared to 0.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - If frame_start && game_en in cycle 0: latch player_x/y, go to SCAN.
  - Cycle 1: bullet_rd_en=1, bullet_addr=0, scan_busy=1.
  - frame_start with game_en=0 is ignored.
- SCAN:
  - In cycle 1+i, addr i is issued (i = 0..NUM_BULLETS-1).
  - In cycle 2+i, bullet_data for entry i is compared.
  - After addr NUM_BULLETS-1 is issued, rd_en drops and the state moves to DRAIN, which performs the final compare.
- Compare, all arithmetic at COORD_W+1 bits:
  - dx = |bx - px|, dy = |by - py|, computed as a true absolute difference with no modular wrap.
  - hit = valid && dx <= HIT_RADIUS && dy <= HIT_RADIUS.
- First hit on entry i (compared in cycle 2+i):
  - Cycle 3+i: collision=1 for exactly one cycle, hit_index=i.
  - Cycle 3+i: scan_busy=0, bullet_rd_en=0, state IDLE.
  - The speculative read of i+1 issued in cycle 2+i is discarded.
  - Remaining entries are not checked.
- No hit: scan_busy is high in cycles 1..NUM_BULLETS+1 and low in cycle NUM_BULLETS+2. collision stays 0.
- At most one collision pulse per accepted frame_start.
- frame_start while scan_busy=1:
  - Not accepted; frame_overrun<=1, cleared only by hard_reset.
  - A frame_start in the same cycle that a scan ends (scan_busy just fell, state IDLE) is accepted normally.
- game_en falling during SCAN/DRAIN:
  - Next cycle: state IDLE, rd_en=0, scan_busy=0.
  - No collision for that frame, even if the compare that same cycle hit.
- hard_reset mid-scan: IDLE next cycle, no collision pulse, all outputs at reset values.
- Player inputs changing mid-scan have no effect; the latched copy is used.
- bullet_addr holds its last value when rd_en=0.

Test Plan:
- All entries valid=0, frame_start with game_en=1 -> addr 0..63 issued in cycles 1..64, scan_busy low at cycle 66, collision never high.
- Player (100,100), entry 5 = (102,97) valid, all others invalid -> collision=1 only in cycle 8, hit_index=5, rd_en=0 from cycle 8, no reads beyond addr 6.
- Boundaries with player (100,100):
  - Entry 0 = (103,103) -> hit.
  - Repeat with (104,100) -> no hit.
  - Repeat with valid=0 at (100,100) -> no hit.
- Wrap check: player (0,0), entry 0 = (1023,0) valid -> no collision. Player (1023,1023), entry 0 = (1021,1020) -> hit.
- Overrun: second frame_start in cycle 20 of a scan -> frame_overrun=1 and stays 1; scan completes unaffected; next frame_start after idle accepted; hard_reset clears the flag.
- Mid-scan abort, hit planted at entry 40:
  - game_en=0 in cycle 10 -> scan_busy=0 and rd_en=0 in cycle 11, no collision.
  - Separately, hard_reset in cycle 30 -> all outputs 0 in cycle 31, no collision.
